// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache between the core ibus and the cbus.
// Hits are served from local arrays, misses refill a whole line with one INCR burst, and device space bypasses the cache.

package icache_pkg;
  typedef enum logic [2:0] {MSIZE1 = 3'd0, MSIZE2, MSIZE4, MSIZE8} msize_t;
  typedef logic [7:0] mlen_t;
  localparam mlen_t MLEN1 = 8'd0;
  typedef enum logic [1:0] {AXI_BURST_FIXED = 2'd0, AXI_BURST_INCR, AXI_BURST_WRAP} axi_burst_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    mlen_t       len;
    axi_burst_t  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
endpackage

module icache_direct_mapped
  import icache_pkg::*;
#(
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  ibus_req_t   ireq,
  output ibus_resp_t  iresp,
  output cbus_req_t   icreq,
  input  cbus_resp_t  icresp,
  input  logic        flush,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int OFS   = $clog2(LINE_WORDS * 8);
  localparam int IDX   = $clog2(LINES);
  localparam int WSEL  = $clog2(LINE_WORDS);
  localparam int TAG_W = 64 - OFS - IDX;

  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, BYPASS, FLUSH} state_t;

  state_t            state, state_nxt;
  logic [63:0]       req_addr;
  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [63:0]       data_mem [LINES*LINE_WORDS];
  logic [63:0]       rd_data;
  logic [WSEL-1:0]   beat_cnt;
  logic              flush_pend;

  logic [IDX-1:0]      req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic [WSEL-1:0]     req_word;
  logic [IDX+WSEL-1:0] rd_addr, wr_addr;
  logic                hit, beat_we, refill_done;

  assign req_idx     = req_addr[OFS+IDX-1:OFS];
  assign req_tag     = req_addr[63:OFS+IDX];
  assign req_word    = req_addr[OFS-1:3];
  assign wr_addr     = {req_idx, beat_cnt};
  assign hit         = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign beat_we     = (state == REFILL) && icresp.ready;
  assign refill_done = beat_we && icresp.last;

  // In IDLE the array read is launched from the incoming address so LOOKUP sees data one cycle later.
  assign rd_addr = (state == IDLE) ? {ireq.addr[OFS+IDX-1:OFS], ireq.addr[OFS-1:3]}
                                   : {req_idx, req_word};

  // NOTE: tag and data arrays are deliberately left out of reset; only the valid bits
  // decide whether their contents mean anything, which keeps them mappable to RAM.
  always_ff @(posedge clk) begin
    if (beat_we) data_mem[wr_addr] <= icresp.data;
    if (refill_done) tag_mem[req_idx] <= req_tag;
    // Forward the beat being written so the post-refill re-read sees the final word too.
    rd_data <= (beat_we && (wr_addr == rd_addr)) ? icresp.data : data_mem[rd_addr];
  end

  // NOTE: every register here uses non-blocking assignment so all updates see
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      req_addr   <= '0;
      valid_q    <= '0;
      beat_cnt   <= '0;
      flush_pend <= 1'b0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && ireq.valid) req_addr <= ireq.addr;
      if (beat_we) beat_cnt <= refill_done ? '0 : beat_cnt + 1'b1;
      if (refill_done) begin
        valid_q[req_idx] <= 1'b1;
        miss_cnt         <= miss_cnt + 32'd1;
      end
      if (state == LOOKUP && ireq.valid && hit) hit_cnt <= hit_cnt + 32'd1;
      if (state == FLUSH) begin
        valid_q    <= '0;
        flush_pend <= 1'b0;
      end else if (flush && state != IDLE) begin
        flush_pend <= 1'b1;
      end
    end
  end

  // NOTE: every output and next-state value gets a default up front so no path
  // through the case statement can leave a latch behind.
  always_comb begin
    state_nxt      = state;
    iresp          = '0;
    icreq.valid    = 1'b0;
    icreq.is_write = 1'b0;
    icreq.size     = MSIZE8;
    icreq.addr     = {req_addr[63:OFS], {OFS{1'b0}}};
    icreq.strobe   = '0;
    icreq.len      = mlen_t'(LINE_WORDS - 1);
    icreq.burst    = AXI_BURST_INCR;

    unique case (state)
      IDLE: begin
        if (flush || flush_pend) state_nxt = FLUSH;
        else if (ireq.valid)     state_nxt = ireq.addr[31] ? LOOKUP : BYPASS;
      end
      LOOKUP: begin
        if (!ireq.valid) begin
          state_nxt = IDLE;
        end else if (hit) begin
          iresp.addr_ok = 1'b1;
          iresp.data_ok = 1'b1;
          iresp.data    = req_addr[2] ? rd_data[63:32] : rd_data[31:0];
          state_nxt     = IDLE;
        end else begin
          state_nxt = REFILL;
        end
      end
      REFILL: begin
        icreq.valid = 1'b1;
        if (refill_done) state_nxt = LOOKUP;
      end
      BYPASS: begin
        icreq.valid = 1'b1;
        icreq.size  = MSIZE4;
        icreq.len   = MLEN1;
        icreq.addr  = req_addr;
        if (icresp.ready) begin
          iresp.addr_ok = 1'b1;
          iresp.data_ok = 1'b1;
          iresp.data    = req_addr[2] ? icresp.data[63:32] : icresp.data[31:0];
          state_nxt     = IDLE;
        end
      end
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Self-checking bench for icache_direct_mapped: directed vector table, multi-cycle corner sequences,
// then random fetches against a line-level cache model and a burst-serving memory.

module tb_icache_direct_mapped;
  import icache_pkg::*;

  localparam int LINES      = 64;
  localparam int LINE_WORDS = 8;
  localparam int LINE_BYTES = LINE_WORDS * 8;

  logic        clk = 1'b0;
  logic        reset;
  ibus_req_t   ireq;
  ibus_resp_t  iresp;
  cbus_req_t   icreq;
  cbus_resp_t  icresp;
  logic        flush;
  logic [31:0] hit_cnt, miss_cnt;

  icache_direct_mapped #(.LINES(LINES), .LINE_WORDS(LINE_WORDS)) dut (
    .clk      (clk),
    .reset    (reset),
    .ireq     (ireq),
    .iresp    (iresp),
    .icreq    (icreq),
    .icresp   (icresp),
    .flush    (flush),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Instruction memory: each 8-byte word has its own distinct contents.
  function automatic logic [63:0] mem_word(input logic [63:0] a);
    logic [31:0] w;
    w = a[31:0] & ~32'h7;
    return {~w ^ 32'h0bad_f00d, w ^ 32'h1357_9bdf};
  endfunction

  function automatic logic [31:0] exp_half(input logic [63:0] a);
    logic [63:0] mw;
    mw = mem_word(a);
    return a[2] ? mw[63:32] : mw[31:0];
  endfunction

  // Cache model: which line holds which tag, plus the two counters.
  bit          m_valid [LINES];
  logic [63:0] m_tag   [LINES];
  int          m_hits   = 0;
  int          m_misses = 0;

  function automatic int m_idx(input logic [63:0] a);
    return int'((a / 64'(LINE_BYTES)) % 64'(LINES));
  endfunction

  function automatic logic [63:0] m_tagof(input logic [63:0] a);
    return a / 64'(LINE_BYTES * LINES);
  endfunction

  function automatic bit m_is_hit(input logic [63:0] a);
    return a[31] && m_valid[m_idx(a)] && (m_tag[m_idx(a)] == m_tagof(a));
  endfunction

  function automatic void model_fill(input logic [63:0] a);
    m_valid[m_idx(a)] = 1'b1;
    m_tag[m_idx(a)]   = m_tagof(a);
    m_misses++;
  endfunction

  function automatic void model_access(input logic [63:0] a);
    if (!a[31]) return;
    if (!m_is_hit(a)) model_fill(a);
    m_hits++;
  endfunction

  function automatic void model_flush();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endfunction

  // Memory side: records every burst and serves beats with random gaps.
  typedef struct packed {
    logic [63:0] addr;
    mlen_t       len;
    msize_t      size;
    axi_burst_t  burst;
    logic        is_write;
    logic [7:0]  strobe;
  } burst_t;

  burst_t burst_q[$];
  int     viol_cnt = 0;

  initial begin : responder
    bit          active;
    int          beat;
    logic [63:0] baddr;
    mlen_t       blen;
    burst_t      b;
    active = 1'b0; beat = 0; baddr = '0; blen = '0;
    icresp = '0;
    forever begin
      @(posedge clk); #2;
      if (icresp.ready) begin
        if (icresp.last) active = 1'b0;
        else beat++;
      end
      icresp = '0;
      if (!reset) begin
        active = 1'b0;
      end else begin
        if (active && (!icreq.valid || icreq.addr !== baddr || icreq.len !== blen)) viol_cnt++;
        if (!active && icreq.valid) begin
          active     = 1'b1;
          beat       = 0;
          baddr      = icreq.addr;
          blen       = icreq.len;
          b.addr     = icreq.addr;
          b.len      = icreq.len;
          b.size     = icreq.size;
          b.burst    = icreq.burst;
          b.is_write = icreq.is_write;
          b.strobe   = icreq.strobe;
          burst_q.push_back(b);
        end
        if (active && $urandom_range(0, 9) < 7) begin
          icresp.ready = 1'b1;
          icresp.last  = (beat == int'(blen));
          icresp.data  = mem_word({baddr[63:3], 3'b000} + 64'(beat) * 64'd8);
        end
      end
    end
  end

  task automatic start_fetch(input logic [63:0] a);
    @(posedge clk); #1;
    ireq.valid = 1'b1;
    ireq.addr  = a;
  endtask

  task automatic wait_resp(output bit got, output int lat, output logic [31:0] d);
    got = 1'b0; lat = 0; d = '0;
    while (!got && lat < 200) begin
      @(negedge clk);
      lat++;
      if (iresp.data_ok) begin
        got = 1'b1;
        d   = iresp.data;
      end
    end
    @(posedge clk); #1;
    ireq.valid = 1'b0;
  endtask

  task automatic flush_pulse();
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
  endtask

  task automatic check_burst(input string name, input int nb, input logic [63:0] a, input mlen_t len,
                             input msize_t size);
    burst_t b;
    check_i({name, ".bursts"}, burst_q.size() - nb, 1);
    if (burst_q.size() > nb) begin
      b = burst_q[nb];
      check({name, ".baddr"}, b.addr, a);
      check({name, ".blen"}, 64'(b.len), 64'(len));
      check({name, ".bsize"}, 64'(b.size), 64'(size));
      check({name, ".battr"}, {b.is_write, b.strobe, b.burst}, {1'b0, 8'h00, AXI_BURST_INCR});
    end
  endtask

  // One fetch judged entirely by the model: hit, line refill or bypass.
  task automatic fetch(input logic [63:0] a, input string name);
    int nb, lat; bit got, was_hit; logic [31:0] d;
    was_hit = m_is_hit(a);
    nb = burst_q.size();
    start_fetch(a);
    wait_resp(got, lat, d);
    check_i({name, ".data_ok"}, int'(got), 1);
    check({name, ".data"}, 64'(d), 64'(exp_half(a)));
    if (!a[31]) check_burst(name, nb, a, MLEN1, MSIZE4);
    else if (was_hit) begin
      check_i({name, ".hit_bursts"}, burst_q.size() - nb, 0);
      check_i({name, ".hit_lat"}, lat, 2);
    end else check_burst(name, nb, a & ~64'(LINE_BYTES - 1), mlen_t'(LINE_WORDS - 1), MSIZE8);
    model_access(a);
    check_i({name, ".hit_cnt"}, int'(hit_cnt), m_hits);
    check_i({name, ".miss_cnt"}, int'(miss_cnt), m_misses);
  endtask

  typedef struct {
    logic [63:0] addr;
    bit          exp_burst;
    logic [63:0] exp_baddr;
    mlen_t       exp_len;
    msize_t      exp_size;
    int          exp_lat;     // 0 = latency not checked
    int          exp_hits;
    int          exp_misses;
  } vec_t;

  vec_t vecs[8];

  initial begin : watchdog
    #800_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int nb, lat; bit got; logic [31:0] d; int dok; logic [63:0] a; int r;

    vecs[0] = '{64'h8000_0004, 1'b1, 64'h8000_0000, 8'd7, MSIZE8, 0, 1, 1};
    vecs[1] = '{64'h8000_0008, 1'b0, 64'h0,         8'd0, MSIZE8, 2, 2, 1};
    vecs[2] = '{64'h8000_0000, 1'b0, 64'h0,         8'd0, MSIZE8, 2, 3, 1};
    vecs[3] = '{64'h8000_1000, 1'b1, 64'h8000_1000, 8'd7, MSIZE8, 0, 4, 2};
    vecs[4] = '{64'h8000_0000, 1'b1, 64'h8000_0000, 8'd7, MSIZE8, 0, 5, 3};
    vecs[5] = '{64'h4060_0004, 1'b1, 64'h4060_0004, 8'd0, MSIZE4, 0, 5, 3};
    vecs[6] = '{64'h8000_103C, 1'b1, 64'h8000_1000, 8'd7, MSIZE8, 0, 6, 4};
    vecs[7] = '{64'h8000_1038, 1'b0, 64'h0,         8'd0, MSIZE8, 2, 7, 4};

    reset = 1'b0;
    ireq  = '0;
    flush = 1'b0;
    model_flush();
    repeat (3) @(posedge clk);
    #1;
    check("reset.iresp", 64'(iresp), 64'h0);
    check("reset.icreq_valid", 64'(icreq.valid), 64'h0);
    check("reset.hit_cnt", 64'(hit_cnt), 64'h0);
    check("reset.miss_cnt", 64'(miss_cnt), 64'h0);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      nb = burst_q.size();
      start_fetch(vecs[i].addr);
      wait_resp(got, lat, d);
      model_access(vecs[i].addr);
      check_i($sformatf("vec%0d.data_ok", i), int'(got), 1);
      check($sformatf("vec%0d.data", i), 64'(d), 64'(exp_half(vecs[i].addr)));
      check_i($sformatf("vec%0d.bursts", i), burst_q.size() - nb, int'(vecs[i].exp_burst));
      if (vecs[i].exp_burst && burst_q.size() > nb) begin
        check($sformatf("vec%0d.baddr", i), burst_q[nb].addr, vecs[i].exp_baddr);
        check($sformatf("vec%0d.blen", i), 64'(burst_q[nb].len), 64'(vecs[i].exp_len));
        check($sformatf("vec%0d.bsize", i), 64'(burst_q[nb].size), 64'(vecs[i].exp_size));
      end
      if (vecs[i].exp_lat != 0) check_i($sformatf("vec%0d.lat", i), lat, vecs[i].exp_lat);
      check_i($sformatf("vec%0d.hit_cnt", i), int'(hit_cnt), vecs[i].exp_hits);
      check_i($sformatf("vec%0d.miss_cnt", i), int'(miss_cnt), vecs[i].exp_misses);
    end

    // Flush in IDLE invalidates a cached line.
    flush_pulse();
    model_flush();
    fetch(64'h8000_1038, "flush_idle");

    // Flush raised mid-refill takes effect only once the refill has been answered.
    a = 64'h8000_2000;
    nb = burst_q.size();
    start_fetch(a);
    repeat (3) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    wait_resp(got, lat, d);
    check_i("flush_refill.data_ok", int'(got), 1);
    check("flush_refill.data", 64'(d), 64'(exp_half(a)));
    check_i("flush_refill.bursts", burst_q.size() - nb, 1);
    model_access(a);
    model_flush();
    check_i("flush_refill.hit_cnt", int'(hit_cnt), m_hits);
    fetch(a, "flush_refill_refetch");

    // Request withdrawn two cycles into REFILL: burst completes silently, line ends up valid.
    a = 64'h8000_2040;
    nb = burst_q.size();
    dok = 0;
    start_fetch(a);
    repeat (4) @(posedge clk);
    #1 ireq.valid = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (iresp.data_ok) dok++;
    end
    model_fill(a);
    check_i("withdraw.data_ok_seen", dok, 0);
    check_i("withdraw.bursts", burst_q.size() - nb, 1);
    check_i("withdraw.miss_cnt", int'(miss_cnt), m_misses);
    check_i("withdraw.hit_cnt", int'(hit_cnt), m_hits);
    fetch(a, "withdraw_refetch");

    // Reset mid-REFILL drops everything back to the cold state.
    start_fetch(64'h8000_3080);
    repeat (4) @(posedge clk);
    #1;
    reset      = 1'b0;
    ireq.valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midreset.hit_cnt", 64'(hit_cnt), 64'h0);
    check("midreset.miss_cnt", 64'(miss_cnt), 64'h0);
    check("midreset.icreq_valid", 64'(icreq.valid), 64'h0);
    check("midreset.iresp", 64'(iresp), 64'h0);
    reset = 1'b1;
    model_flush();
    m_hits   = 0;
    m_misses = 0;
    fetch(64'h8000_2040, "midreset_refetch");
    fetch(64'h8000_3080, "midreset_second");

    // Random mix of conflicting cached fetches, bypass reads and flushes.
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 99);
      if (r < 5) begin
        flush_pulse();
        model_flush();
      end else if (r < 15) begin
        a = 64'h4000_0000 | 64'($urandom & 32'h00ff_fffc);
        fetch(a, $sformatf("rnd%0d.byp", i));
      end else begin
        a = 64'h8000_0000
          | (64'($urandom_range(0, 1)) << 12)
          | (64'($urandom_range(0, 1)) << 32)
          | (64'($urandom_range(0, 3) * 17) << 6)
          | (64'($urandom_range(0, 15)) << 2);
        fetch(a, $sformatf("rnd%0d", i));
      end
    end

    check_i("cbus_request_stability", viol_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
